tdm_demux_1to4: RTL and testbench



---
 rtl/tdm_demux_if.sv | 33 +++
 rtl/tdm_demux_1to4.sv | 121 ++++++++++++
 tb/tb_tdm_demux_1to4.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if
//   Bundles the serial TDM input beat and the parallel frame output of the
//   1-to-4 TDM demultiplexer.
//   Ports (signals):
//     in_data   [WIDTH]    slot payload
//     in_valid             beat qualifier (no backpressure)
//     in_sync              beat is slot 0 (start of frame)
//     out_data  [4*WIDTH]  last complete frame, lane k at [k*WIDTH +: WIDTH]
//     out_valid            one-cycle pulse, out_data just updated
//     locked               frame alignment held
//     sync_err             one-cycle pulse on a framing violation
//   Modports: master = stream source / frame sink, slave = demultiplexer.
interface tdm_demux_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_sync;
  logic [4*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               locked;
  logic               sync_err;

  modport master (
    output in_data, in_valid, in_sync,
    input  out_data, out_valid, locked, sync_err
  );

  modport slave (
    input  in_data, in_valid, in_sync,
    output out_data, out_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4
//   Receive-side TDM demultiplexer. Collects four WIDTH-bit slots per frame
//   (slot 0 flagged by in_sync) and publishes the whole frame as one
//   registered 4*WIDTH word with a single-cycle out_valid strobe.
//   Ports:
//     clk   clock, all state updates on the rising edge
//     rst   synchronous active-high reset
//     bus   tdm_demux_if slave modport (in_data/in_valid/in_sync in,
//           out_data/out_valid/locked/sync_err out)
module tdm_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         slot_reg, slot_next;
  logic [4*WIDTH-1:0] out_data_reg, out_data_next;
  logic               out_valid_reg, out_valid_next;
  logic               sync_err_reg, sync_err_next;

  // Shadow lanes 0..2 hold the partial frame; lane 3 comes straight from the
  // closing beat so the output word is written in one shot.
  logic [2:0]         shadow_we;
  logic [WIDTH-1:0]   shadow0, shadow1, shadow2;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shadow
      logic [WIDTH-1:0] lane_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (shadow_we[gi]) begin
          lane_reg <= bus.in_data;
        end
      end
    end
  endgenerate

  assign shadow0 = g_shadow[0].lane_reg;
  assign shadow1 = g_shadow[1].lane_reg;
  assign shadow2 = g_shadow[2].lane_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      slot_reg      <= 2'd0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      sync_err_reg  <= sync_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    sync_err_next  = 1'b0;
    shadow_we      = 3'b000;

    if (bus.in_valid) begin
      case (state_reg)
        HUNT: begin
          // Non-sync beats while hunting are silently dropped.
          if (bus.in_sync) begin
            shadow_we[0] = 1'b1;
            slot_next    = 2'd1;
            state_next   = LOCK;
          end
        end
        LOCK: begin
          if (bus.in_sync && (slot_reg != 2'd0)) begin
            // Early sync: abandon the partial frame and restart on this beat.
            sync_err_next = 1'b1;
            shadow_we[0]  = 1'b1;
            slot_next     = 2'd1;
          end else if (!bus.in_sync && (slot_reg == 2'd0)) begin
            // Expected a frame start but got payload: alignment is lost.
            sync_err_next = 1'b1;
            state_next    = HUNT;
          end else if (bus.in_sync) begin
            shadow_we[0] = 1'b1;
            slot_next    = 2'd1;
          end else if (slot_reg == 2'd3) begin
            out_data_next  = {bus.in_data, shadow2, shadow1, shadow0};
            out_valid_next = 1'b1;
            slot_next      = 2'd0;
          end else begin
            if (slot_reg == 2'd1) begin
              shadow_we[1] = 1'b1;
            end else begin
              shadow_we[2] = 1'b1;
            end
            slot_next = slot_reg + 2'd1;
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.locked    = (state_reg == LOCK);
  assign bus.sync_err  = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  tdm_demux_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        r;
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic [31:0] eod;
    logic        eov;
    logic        elk;
    logic        eer;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic v, logic s, logic [7:0] d,
                              logic [31:0] eod, logic eov, logic elk, logic eer);
    vec_t e;
    e.r = r; e.v = v; e.s = s; e.d = d;
    e.eod = eod; e.eov = eov; e.elk = elk; e.eer = eer;
    tbl.push_back(e);
  endfunction

  task automatic compare(input string tag, input int idx, input logic [31:0] eod,
                         input logic eov, input logic elk, input logic eer);
    checks++;
    if (bus.out_data !== eod) begin
      failures++;
      $display("FAIL %s[%0d] out_data got=%h exp=%h", tag, idx, bus.out_data, eod);
    end
    checks++;
    if (bus.out_valid !== eov) begin
      failures++;
      $display("FAIL %s[%0d] out_valid got=%b exp=%b", tag, idx, bus.out_valid, eov);
    end
    checks++;
    if (bus.locked !== elk) begin
      failures++;
      $display("FAIL %s[%0d] locked got=%b exp=%b", tag, idx, bus.locked, elk);
    end
    checks++;
    if (bus.sync_err !== eer) begin
      failures++;
      $display("FAIL %s[%0d] sync_err got=%b exp=%b", tag, idx, bus.sync_err, eer);
    end
  endtask

  task automatic drive_edge(input logic r, input logic v, input logic s, input logic [7:0] d);
    rst          = r;
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: a queue of accepted slots for the frame in
  // progress; empty queue means the next beat must be a frame start.
  logic        m_locked;
  logic [7:0]  m_q[$];
  logic [31:0] m_out;
  logic        m_ov;
  logic        m_err;

  task automatic model_step(input logic r, input logic v, input logic s, input logic [7:0] d);
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_q.delete();
      m_out = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1'b1;
        end
      end else if (s) begin
        if (m_q.size() != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          m_out = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_ov  = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;

    // reset
    add(1, 0, 0, 8'h00, 32'h0, 0, 0, 0);
    // single frame
    add(0, 1, 1, 8'h11, 32'h0, 0, 1, 0);
    add(0, 1, 0, 8'h22, 32'h0, 0, 1, 0);
    add(0, 1, 0, 8'h33, 32'h0, 0, 1, 0);
    add(0, 1, 0, 8'h44, 32'h44332211, 1, 1, 0);
    // three back-to-back frames
    add(0, 1, 1, 8'h01, 32'h44332211, 0, 1, 0);
    add(0, 1, 0, 8'h02, 32'h44332211, 0, 1, 0);
    add(0, 1, 0, 8'h03, 32'h44332211, 0, 1, 0);
    add(0, 1, 0, 8'h04, 32'h04030201, 1, 1, 0);
    add(0, 1, 1, 8'h05, 32'h04030201, 0, 1, 0);
    add(0, 1, 0, 8'h06, 32'h04030201, 0, 1, 0);
    add(0, 1, 0, 8'h07, 32'h04030201, 0, 1, 0);
    add(0, 1, 0, 8'h08, 32'h08070605, 1, 1, 0);
    add(0, 1, 1, 8'h09, 32'h08070605, 0, 1, 0);
    add(0, 1, 0, 8'h0A, 32'h08070605, 0, 1, 0);
    add(0, 1, 0, 8'h0B, 32'h08070605, 0, 1, 0);
    add(0, 1, 0, 8'h0C, 32'h0C0B0A09, 1, 1, 0);
    // frame with 0..3 idle gaps between beats (idle data is junk)
    add(0, 1, 1, 8'h21, 32'h0C0B0A09, 0, 1, 0);
    add(0, 0, 1, 8'hFF, 32'h0C0B0A09, 0, 1, 0);
    add(0, 1, 0, 8'h22, 32'h0C0B0A09, 0, 1, 0);
    add(0, 0, 0, 8'hEE, 32'h0C0B0A09, 0, 1, 0);
    add(0, 0, 1, 8'hDD, 32'h0C0B0A09, 0, 1, 0);
    add(0, 1, 0, 8'h23, 32'h0C0B0A09, 0, 1, 0);
    add(0, 0, 0, 8'hCC, 32'h0C0B0A09, 0, 1, 0);
    add(0, 0, 0, 8'hBB, 32'h0C0B0A09, 0, 1, 0);
    add(0, 0, 1, 8'hAA, 32'h0C0B0A09, 0, 1, 0);
    add(0, 1, 0, 8'h24, 32'h24232221, 1, 1, 0);
    add(0, 0, 0, 8'h00, 32'h24232221, 0, 1, 0);
    // resync on slot 2
    add(0, 1, 1, 8'hA1, 32'h24232221, 0, 1, 0);
    add(0, 1, 0, 8'hA2, 32'h24232221, 0, 1, 0);
    add(0, 1, 1, 8'hB1, 32'h24232221, 0, 1, 1);
    add(0, 1, 0, 8'hB2, 32'h24232221, 0, 1, 0);
    add(0, 1, 0, 8'hB3, 32'h24232221, 0, 1, 0);
    add(0, 1, 0, 8'hB4, 32'hB4B3B2B1, 1, 1, 0);
    // lost alignment at slot 0, then relock
    add(0, 1, 0, 8'h55, 32'hB4B3B2B1, 0, 0, 1);
    add(0, 1, 0, 8'h56, 32'hB4B3B2B1, 0, 0, 0);
    add(0, 1, 0, 8'h57, 32'hB4B3B2B1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 32'hB4B3B2B1, 0, 0, 0);
    add(0, 1, 1, 8'hC1, 32'hB4B3B2B1, 0, 1, 0);
    add(0, 1, 0, 8'hC2, 32'hB4B3B2B1, 0, 1, 0);
    add(0, 1, 0, 8'hC3, 32'hB4B3B2B1, 0, 1, 0);
    add(0, 1, 0, 8'hC4, 32'hC4C3C2C1, 1, 1, 0);
    // reset mid-frame, then a fresh frame
    add(0, 1, 1, 8'hD1, 32'hC4C3C2C1, 0, 1, 0);
    add(0, 1, 0, 8'hD2, 32'hC4C3C2C1, 0, 1, 0);
    add(1, 1, 0, 8'hD3, 32'h0, 0, 0, 0);
    add(0, 1, 0, 8'hD4, 32'h0, 0, 0, 0);
    add(0, 1, 1, 8'hE1, 32'h0, 0, 1, 0);
    add(0, 1, 0, 8'hE2, 32'h0, 0, 1, 0);
    add(0, 1, 0, 8'hE3, 32'h0, 0, 1, 0);
    add(0, 1, 0, 8'hE4, 32'hE4E3E2E1, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_edge(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      $display("vec %0d: rst=%b v=%b s=%b d=%h -> out=%h ov=%b lk=%b err=%b",
               i, tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d,
               bus.out_data, bus.out_valid, bus.locked, bus.sync_err);
      compare("vec", i, tbl[i].eod, tbl[i].eov, tbl[i].elk, tbl[i].eer);
    end

    // Randomized phase against the frame-level model, starting from reset.
    model_step(1'b1, 1'b0, 1'b0, 8'h00);
    drive_edge(1'b1, 1'b0, 1'b0, 8'h00);
    compare("rnd_rst", 0, m_out, m_ov, m_locked, m_err);
    for (int i = 0; i < 1500; i++) begin
      logic r, v, s;
      logic [7:0] d;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_q.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                 s = ($urandom_range(0, 15) == 0);
      d = 8'($urandom);
      model_step(r, v, s, d);
      drive_edge(r, v, s, d);
      if (m_ov || m_err || r)
        $display("rnd %0d: rst=%b v=%b s=%b d=%h -> out=%h ov=%b lk=%b err=%b",
                 i, r, v, s, d, bus.out_data, bus.out_valid, bus.locked, bus.sync_err);
      compare("rnd", i, m_out, m_ov, m_locked, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
